// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory stall bridge: funct3 encodings,
// bridge FSM states and byte-enable / alignment helpers.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  // Size comes from funct3[1:0]; reserved encodings act as word accesses.
  function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   be_gen = 4'b0001 << off;
      2'b01:   be_gen = 4'b0011 << {off[1], 1'b0};
      default: be_gen = 4'b1111;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   is_misaligned = 1'b0;
      2'b01:   is_misaligned = off[0];
      default: is_misaligned = |off;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: formats a bus read word into core load data
// and replicates store data across the byte lanes.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] rword,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rword[{off, 3'b000} +: 8];
    half_v = rword[{off[1], 4'b0000} +: 16];
    case (funct3)
      F3_B:    load_data = {{24{byte_v[7]}}, byte_v};
      F3_BU:   load_data = {24'h000000, byte_v};
      F3_H:    load_data = {{16{half_v[15]}}, half_v};
      F3_HU:   load_data = {16'h0000, half_v};
      default: load_data = rword;
    endcase
  end

  always_comb begin
    case (funct3[1:0])
      2'b00:   store_data = {4{wdata[7:0]}};
      2'b01:   store_data = {2{wdata[15:0]}};
      default: store_data = wdata;
    endcase
  end

endmodule

// File: rtl/dmem_stall_bridge.sv
// Converts single-cycle core loads/stores into req/ack bus beats, stalling the
// core until completion. Optional macro: DMEM_MISALIGN_TRAP_EN.
module dmem_stall_bridge
  import dmem_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        AccessFault,
  output logic        Misaligned,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        we_q, fault_q, mis_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  be_q;
  logic [2:0]  f3_q;
  logic [CNT_W-1:0] cnt_q;
  logic        pending, trap;
  logic [31:0] load_data;

  assign pending = MemRead | MemWrite;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign trap = is_misaligned(Funct3[1:0], Addr[1:0]);
`else
  assign trap = 1'b0;
`endif

  dmem_lane_align u_align (
    .funct3     (f3_q),
    .off        (addr_q[1:0]),
    .rword      (bus_rdata),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_data (bus_wdata)
  );

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pending) state_d = trap ? DONE : REQ;
      REQ:     if (bus_ack || cnt_q == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (pending) begin
          we_q    <= MemWrite;
          addr_q  <= Addr;
          be_q    <= be_gen(Funct3[1:0], Addr[1:0]);
          wdata_q <= WriteData;
          f3_q    <= Funct3;
          cnt_q   <= '0;
          rdata_q <= '0;
          fault_q <= 1'b0;
          mis_q   <= trap;
        end
        REQ: begin
          // Ack wins over the watchdog on the final allowed cycle.
          if (bus_ack) begin
            rdata_q <= we_q ? '0 : load_data;
          end else if (cnt_q == LAST) begin
            rdata_q <= '0;
            fault_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign Stall       = pending && (state_q != DONE);
  assign ReadData    = rdata_q;
  assign AccessFault = (state_q == DONE) && fault_q;
  assign Misaligned  = (state_q == DONE) && mis_q;
  assign bus_req     = (state_q == REQ);
  assign bus_we      = we_q;
  assign bus_addr    = {addr_q[31:2], 2'b00};
  assign bus_be      = be_q;

endmodule
